// File: rtl/fetch_stage_pkg.sv
// Shared RV32I types for the front end: opcode encoding, fetch FSM states and
// the canonical NOP word that the fetch stage and hazard unit insert as a bubble.
package fetch_stage_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_FENCE    = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory port: request held stable until the one-cycle response pulse.
interface fetch_stage_if;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;

    modport master (output inst_read, inst_addr, input inst_resp, inst_rdata);
    modport slave  (input inst_read, inst_addr, output inst_resp, inst_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush/hold/load/bubble priority and decode field slices.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = RV32I_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic        valid_id,
    output rv32i_opcode opcode_id,
    output logic [2:0]  funct3_id,
    output logic [6:0]  funct7_id,
    output logic [4:0]  rs1_id,
    output logic [4:0]  rs2_id,
    output logic [4:0]  rd_id
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_id <= NOP_INSTR;
            pc_id    <= 32'd0;
            valid_id <= 1'b0;
        end else if (flush) begin
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                instr_id <= load_instr;
                pc_id    <= load_pc;
                valid_id <= 1'b1;
            end else begin
                // bubble keeps pc_id so decode still sees the last real PC
                instr_id <= NOP_INSTR;
                valid_id <= 1'b0;
            end
        end
    end

    assign opcode_id = rv32i_opcode'(instr_id[6:0]);
    assign funct3_id = instr_id[14:12];
    assign funct7_id = instr_id[31:25];
    assign rs1_id    = instr_id[19:15];
    assign rs2_id    = instr_id[24:20];
    assign rd_id     = instr_id[11:7];

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, drives the instruction memory port and
// feeds the IF/ID register; tolerates variable latency, decode stalls and EX redirects.
//
//   state | meaning
//   FETCH | request at pc_q outstanding; squash_q marks a response to be discarded
//   HOLD  | word fetched while decode stalled, parked in the hold buffer
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0060,
    parameter logic [31:0] NOP_INSTR = RV32I_NOP
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_stage_if.master         mem,
    input  logic                  stall_id,
    input  logic                  redirect_ex,
    input  logic [31:0]           redirect_pc_ex,
    output logic [31:0]           instr_id,
    output logic [31:0]           pc_id,
    output logic                  valid_id,
    output rv32i_opcode           opcode_id,
    output logic [2:0]            funct3_id,
    output logic [6:0]            funct7_id,
    output logic [4:0]            rs1_id,
    output logic [4:0]            rs2_id,
    output logic [4:0]            rd_id
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pending_pc_q, pending_pc_d;
    logic         squash_q, squash_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic         read_req;
    logic         deliver;
    logic [31:0]  deliver_instr;
    logic [31:0]  deliver_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pending_pc_q <= 32'd0;
            squash_q     <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            squash_q     <= squash_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_pc_d  = pending_pc_q;
        squash_d      = squash_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        read_req      = 1'b0;
        deliver       = 1'b0;
        deliver_instr = hold_instr_q;
        deliver_pc    = hold_pc_q;
        case (state_q)
            FETCH: begin
                read_req = 1'b1;
                if (mem.inst_resp) begin
                    if (squash_q || redirect_ex) begin
                        pc_d     = redirect_ex ? redirect_pc_ex : pending_pc_q;
                        squash_d = 1'b0;
                    end else if (!stall_id) begin
                        deliver       = 1'b1;
                        deliver_instr = mem.inst_rdata;
                        deliver_pc    = pc_q;
                        pc_d          = pc_q + 32'd4;
                    end else begin
                        hold_instr_d = mem.inst_rdata;
                        hold_pc_d    = pc_q;
                        pc_d         = pc_q + 32'd4;
                        state_d      = HOLD;
                    end
                end else if (redirect_ex) begin
                    // address must stay put until the in-flight response returns
                    pending_pc_d = redirect_pc_ex;
                    squash_d     = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_ex) begin
                    pc_d         = redirect_pc_ex;
                    hold_instr_d = NOP_INSTR;
                    state_d      = FETCH;
                end else if (!stall_id) begin
                    deliver = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign mem.inst_read = read_req;
    assign mem.inst_addr = pc_q;

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_ex),
        .hold       (stall_id),
        .load       (deliver),
        .load_instr (deliver_instr),
        .load_pc    (deliver_pc),
        .instr_id   (instr_id),
        .pc_id      (pc_id),
        .valid_id   (valid_id),
        .opcode_id  (opcode_id),
        .funct3_id  (funct3_id),
        .funct7_id  (funct7_id),
        .rs1_id     (rs1_id),
        .rs2_id     (rs2_id),
        .rd_id      (rd_id)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: the reference is the architectural instruction
// stream (sequential PCs, restarted at each redirect target) checked as decode consumes it.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0060;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          CYCLES = 4000;

    logic        clk;
    logic        rst;
    logic        stall_id;
    logic        redirect_ex;
    logic [31:0] redirect_pc_ex;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic        valid_id;
    logic [6:0]  opcode_id;
    logic [2:0]  funct3_id;
    logic [6:0]  funct7_id;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [4:0]  rd_id;

    fetch_stage_if mem_bus ();

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem            (mem_bus),
        .stall_id       (stall_id),
        .redirect_ex    (redirect_ex),
        .redirect_pc_ex (redirect_pc_ex),
        .instr_id       (instr_id),
        .pc_id          (pc_id),
        .valid_id       (valid_id),
        .opcode_id      (opcode_id),
        .funct3_id      (funct3_id),
        .funct7_id      (funct7_id),
        .rs1_id         (rs1_id),
        .rs2_id         (rs2_id),
        .rd_id          (rd_id)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          consumed = 0;
    logic [31:0] exp_q[$];
    logic        prev_redirect = 1'b0;

    bit          busy = 1'b0;
    logic [31:0] maddr = 32'd0;
    int          mcnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every instruction decode accepts must be the next one in the stream.
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        logic [31:0] exp_w;
        if (!rst) begin
            if (prev_redirect)
                check("flush_after_redirect", {31'd0, valid_id, instr_id}, {31'd0, 1'b0, NOP});
            if (valid_id && !stall_id && !redirect_ex) begin
                if (exp_q.size() == 0) begin
                    check("stream_nonempty", 64'd0, 64'd1);
                end else begin
                    exp_pc = exp_q.pop_front();
                    exp_w  = mem_word(exp_pc);
                    exp_q.push_back(exp_pc + 32'd4);
                    check("pc_id", {32'd0, pc_id}, {32'd0, exp_pc});
                    check("instr_id", {32'd0, instr_id}, {32'd0, exp_w});
                    check("fields", {32'd0, funct7_id, rs2_id, rs1_id, funct3_id, rd_id, opcode_id},
                          {32'd0, exp_w});
                    consumed++;
                end
            end
            prev_redirect = redirect_ex;
        end else begin
            prev_redirect = 1'b0;
        end
    end

    task automatic step_memory();
        mem_bus.inst_resp = 1'b0;
        if (!busy && mem_bus.inst_read) begin
            busy  = 1'b1;
            maddr = mem_bus.inst_addr;
            mcnt  = $urandom_range(0, 3);
        end else if (busy) begin
            check("addr_stable", {31'd0, mem_bus.inst_read, mem_bus.inst_addr}, {31'd0, 1'b1, maddr});
            if (mcnt > 0) mcnt--;
        end
        if (busy && mcnt == 0) begin
            mem_bus.inst_resp  = 1'b1;
            mem_bus.inst_rdata = mem_word(maddr);
            busy = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] tgt;
        rst = 1'b1;
        stall_id = 1'b0;
        redirect_ex = 1'b0;
        redirect_pc_ex = 32'd0;
        mem_bus.inst_resp = 1'b0;
        mem_bus.inst_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_state", {valid_id, instr_id, pc_id}, {1'b0, NOP, 32'd0});
        check("rst_addr", {32'd0, mem_bus.inst_addr}, {32'd0, RST_PC});
        rst = 1'b0;
        #1;
        check("read_after_rst", {63'd0, mem_bus.inst_read}, 64'd1);
        exp_q.push_back(RST_PC);

        for (int c = 0; c < CYCLES; c++) begin
            @(posedge clk);
            #2;
            if (c == 1)
                check("first_fetch", {valid_id, rd_id, pc_id, mem_bus.inst_addr},
                      {1'b1, 5'd1, RST_PC, RST_PC + 32'd4});
            step_memory();
            if (c == 0) begin
                mem_bus.inst_resp  = 1'b1;
                mem_bus.inst_rdata = mem_word(RST_PC);
                busy = 1'b0;
            end
            stall_id    = (c >= 2) && ($urandom_range(0, 3) == 0);
            redirect_ex = (c >= 2) && ($urandom_range(0, 11) == 0);
            if (redirect_ex) begin
                case ($urandom_range(0, 3))
                    0:       tgt = 32'hFFFF_FFF8;
                    1:       tgt = 32'h0000_0200;
                    default: tgt = $urandom() & 32'hFFFF_FFFC;
                endcase
                redirect_pc_ex = tgt;
                exp_q.delete();
                exp_q.push_back(tgt);
            end
        end

        // Leave a request outstanding, then hit it with an asynchronous reset.
        @(posedge clk);
        #2;
        stall_id = 1'b0;
        redirect_ex = 1'b0;
        mem_bus.inst_resp = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
            mem_bus.inst_resp = 1'b0;
        end
        check("outstanding_read", {63'd0, mem_bus.inst_read}, 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", {valid_id, instr_id, pc_id}, {1'b0, NOP, 32'd0});
        check("async_rst_addr", {32'd0, mem_bus.inst_addr}, {32'd0, RST_PC});
        @(posedge clk);
        #2;
        rst = 1'b0;
        busy = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST_PC);
        #1;
        check("refetch_after_rst", {31'd0, mem_bus.inst_read, mem_bus.inst_addr}, {31'd0, 1'b1, RST_PC});
        mem_bus.inst_resp  = 1'b1;
        mem_bus.inst_rdata = mem_word(RST_PC);
        @(posedge clk);
        #2;
        mem_bus.inst_resp = 1'b0;
        check("post_rst_fetch", {valid_id, pc_id, mem_bus.inst_addr}, {1'b1, RST_PC, RST_PC + 32'd4});
        @(negedge clk);
        @(posedge clk);
        #2;

        check("progress", {63'd0, consumed >= 200}, 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
